if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the RISC-V core; sits directly upstream of the instruction memory.

---
 rtl/rv_pkg.sv | 14 +
 rtl/if_fetch_stage_pc_reg.sv | 30 +++
 rtl/if_fetch_stage.sv | 64 ++++++
 tb/tb_if_fetch_stage.sv | 113 +++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V core constants and the IF/ID pipeline bundle
//   XLEN    - datapath width
//   RV_NOP  - addi x0,x0,0, used as the pipeline bubble
//   ifid_t  - IF/ID register contents {valid, inst, pc, pc_plus4}
package rv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } ifid_t;
endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// pc_reg: program counter with next-PC priority mux (rst > redirect > flush > stall > advance)
//   clk, rst          - clock, synchronous active-high reset
//   stall             - hold PC
//   flush             - advance PC even while stalled
//   redirect          - load word-aligned redirect_pc
//   redirect_pc       - redirect target byte address
//   pc                - current word-aligned PC
module pc_reg
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc
);
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_next;
   // flush discards the held instruction, so the PC must move on even under stall
   always_comb
      w_pc_next = redirect ? (redirect_pc & ~32'h3) : (flush || !stall) ? r_pc + 32'd4 : r_pc;
   always_ff @(posedge clk)
      if (rst) r_pc <= RESET_PC & ~32'h3;
      else     r_pc <= w_pc_next;
   assign pc = r_pc;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with IF/ID register, stall/flush/redirect and perf counters
//   clk, rst                     - clock, synchronous active-high reset
//   imem_addr / imem_inst        - fetch address out, combinational instruction in
//   stall, flush, redirect(_pc)  - hazard and control-flow inputs from later stages
//   ifid_valid/inst/pc/pc_plus4  - IF/ID pipeline register
//   fetch_count, bubble_count    - saturating accepted-fetch and bubble counters
module if_fetch_stage
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INST = RV_NOP,
   parameter int              CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [XLEN-1:0]  imem_inst,
   input  logic             stall,
   input  logic             redirect,
   input  logic [XLEN-1:0]  redirect_pc,
   input  logic             flush,
   output logic             ifid_valid,
   output logic [XLEN-1:0]  ifid_inst,
   output logic [XLEN-1:0]  ifid_pc,
   output logic [XLEN-1:0]  ifid_pc_plus4,
   output logic [CNT_W-1:0] fetch_count,
   output logic [CNT_W-1:0] bubble_count
);
   logic [XLEN-1:0]  w_pc;
   logic             w_bubble;
   logic             w_fetch;
   ifid_t            r_ifid;
   logic [CNT_W-1:0] r_fetch_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;
   pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .redirect(redirect), .redirect_pc(redirect_pc), .pc(w_pc)
   );
   assign w_bubble = redirect || flush;
   assign w_fetch  = !w_bubble && !stall;
   // a bubble keeps the previous pc fields so downstream sees a stable (but invalid) tag
   always_ff @(posedge clk)
      if (rst) begin
         r_ifid       <= '{valid: 1'b0, inst: NOP_INST, pc: '0, pc_plus4: 32'd4};
         r_fetch_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_bubble) begin
            r_ifid.valid <= 1'b0;
            r_ifid.inst  <= NOP_INST;
         end else if (w_fetch) begin
            r_ifid <= '{valid: 1'b1, inst: imem_inst, pc: w_pc, pc_plus4: w_pc + 32'd4};
         end
         if (w_fetch && !(&r_fetch_cnt))   r_fetch_cnt  <= r_fetch_cnt + CNT_W'(1);
         if (w_bubble && !(&r_bubble_cnt)) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   assign imem_addr     = w_pc;
   assign ifid_valid    = r_ifid.valid;
   assign ifid_inst     = r_ifid.inst;
   assign ifid_pc       = r_ifid.pc;
   assign ifid_pc_plus4 = r_ifid.pc_plus4;
   assign fetch_count   = r_fetch_cnt;
   assign bubble_count  = r_bubble_cnt;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed table-driven check of if_fetch_stage
module tb_if_fetch_stage;
   logic        clk = 0;
   logic        rst, stall, redirect, flush;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr, imem_inst, ifid_inst, ifid_pc, ifid_pc_plus4, fetch_count, bubble_count;
   logic        ifid_valid;
   logic [31:0] s_addr, s_inst, s_pc, s_pc4;
   logic        s_valid;
   logic [1:0]  s_fc, s_bc;
   logic [31:0] mem [64];
   int checks = 0, failures = 0;

   always #5 clk = ~clk;
   assign imem_inst = mem[imem_addr[7:2]];

   if_fetch_stage dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
      .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc(ifid_pc),
      .ifid_pc_plus4(ifid_pc_plus4), .fetch_count(fetch_count), .bubble_count(bubble_count)
   );

   if_fetch_stage #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .imem_addr(s_addr), .imem_inst(32'h0000_0013),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
      .ifid_valid(s_valid), .ifid_inst(s_inst), .ifid_pc(s_pc),
      .ifid_pc_plus4(s_pc4), .fetch_count(s_fc), .bubble_count(s_bc)
   );

   typedef struct {
      logic        stall, redirect, flush;
      logic [31:0] rpc;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] inst, pc, fc, bc;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic r, input logic f, input logic [31:0] rp);
      stall = s; redirect = r; flush = f; redirect_pc = rp;
      @(posedge clk); #1;
   endtask

   task automatic chk_state(input string tag, input logic [31:0] addr, input logic v,
                            input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] fc, input logic [31:0] bc);
      chk({tag, ".addr"}, imem_addr, addr);
      chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
      chk({tag, ".inst"}, ifid_inst, inst);
      chk({tag, ".pc"}, ifid_pc, pc);
      chk({tag, ".pc4"}, ifid_pc_plus4, pc + 32'd4);
      chk({tag, ".fcnt"}, fetch_count, fc);
      chk({tag, ".bcnt"}, bubble_count, bc);
   endtask

   vec_t v [13];

   initial begin
      mem[0] = 32'h0050_0093;
      for (int i = 1; i < 64; i++) mem[i] = 32'hA000_0000 | i;
      //       stall redir flush rpc           addr          valid inst          pc            fc  bc
      v[0]  = '{0, 0, 0, 32'h0,         32'h4,        1, 32'h0050_0093, 32'h0,        1, 0};
      v[1]  = '{0, 0, 0, 32'h0,         32'h8,        1, 32'hA000_0001, 32'h4,        2, 0};
      v[2]  = '{1, 0, 0, 32'h0,         32'h8,        1, 32'hA000_0001, 32'h4,        2, 0};
      v[3]  = '{1, 0, 0, 32'h0,         32'h8,        1, 32'hA000_0001, 32'h4,        2, 0};
      v[4]  = '{1, 0, 0, 32'h0,         32'h8,        1, 32'hA000_0001, 32'h4,        2, 0};
      v[5]  = '{0, 0, 0, 32'h0,         32'hC,        1, 32'hA000_0002, 32'h8,        3, 0};
      v[6]  = '{0, 0, 1, 32'h0,         32'h10,       0, 32'h0000_0013, 32'h8,        3, 1};
      v[7]  = '{0, 0, 0, 32'h0,         32'h14,       1, 32'hA000_0004, 32'h10,       4, 1};
      v[8]  = '{1, 1, 0, 32'h42,        32'h40,       0, 32'h0000_0013, 32'h10,       4, 2};
      v[9]  = '{0, 0, 0, 32'h0,         32'h44,       1, 32'hA000_0010, 32'h40,       5, 2};
      v[10] = '{1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 32'h0000_0013, 32'h40,      5, 3};
      v[11] = '{0, 0, 0, 32'h0,         32'h0,        1, 32'hA000_003F, 32'hFFFF_FFFC, 6, 3};
      v[12] = '{0, 0, 0, 32'h0,         32'h4,        1, 32'h0050_0093, 32'h0,        7, 3};

      rst = 1; stall = 0; redirect = 0; flush = 0; redirect_pc = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk_state("reset", 32'h0, 0, 32'h0000_0013, 32'h0, 0, 0);

      for (int i = 0; i < 13; i++) begin
         step(v[i].stall, v[i].redirect, v[i].flush, v[i].rpc);
         chk_state($sformatf("vec%0d", i), v[i].addr, v[i].valid, v[i].inst, v[i].pc, v[i].fc, v[i].bc);
      end

      step(1, 0, 0, 0);
      chk("prestall.addr", imem_addr, 32'h4);
      rst = 1;
      step(1, 0, 0, 0);
      rst = 0;
      chk_state("rst_mid_stall", 32'h0, 0, 32'h0000_0013, 32'h0, 0, 0);
      chk("sat.reset.fc", {30'd0, s_fc}, 32'd0);

      repeat (5) step(0, 0, 0, 0);
      chk("sat.fc", {30'd0, s_fc}, 32'd3);
      chk("sat.run.fc", fetch_count, 32'd5);
      repeat (4) step(0, 0, 1, 0);
      chk("sat.bc", {30'd0, s_bc}, 32'd3);
      chk("sat.fc_hold", {30'd0, s_fc}, 32'd3);
      chk("sat.run.bc", bubble_count, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
